// File: rtl/cache_control_pkg.sv
// rtl/cache_control_pkg.sv - shared types and helpers for the L1 cache controller
package cache_control_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_cache_state;

  typedef logic lc3b_way;

  localparam lc3b_way WAY1 = 1'b0;
  localparam lc3b_way WAY2 = 1'b1;

  // Dirty bit of the way that would be evicted from the indexed set.
  function automatic logic victim_dirty(input lc3b_way way, input logic d1, input logic d2);
    return (way == WAY2) ? d2 : d1;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// rtl/cache_control_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (inc && (count != {width{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - control FSM for the 2-way set-associative L1 cache
module cache_control
  import cache_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             hit,
  input  logic             hit_way,
  input  logic             lru_way,
  input  logic             dirty1_out,
  input  logic             dirty2_out,
  output logic             load_tag1,
  output logic             load_tag2,
  output logic             load_valid1,
  output logic             load_valid2,
  output logic             load_data1,
  output logic             load_data2,
  output logic             load_dirty1,
  output logic             load_dirty2,
  output logic             load_lru,
  output logic             lru_in,
  output logic             valid1_in,
  output logic             valid2_in,
  output logic             dirty1_in,
  output logic             dirty2_in,
  output logic             eviction,
  output logic             data_src,
  output logic             paddr_sel,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  lc3b_cache_state state, next_state;
  logic            refill;
  logic            refill_set, refill_clr;
  logic            hit_inc, miss_inc, wb_inc;
  logic            req, wr;

  assign req = mem_read | mem_write;
  assign wr  = mem_write;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Set on a line fill so the completing hit is not counted as a hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refill <= 1'b0;
    end else if (refill_set) begin
      refill <= 1'b1;
    end else if (refill_clr) begin
      refill <= 1'b0;
    end
  end

  always_comb begin
    next_state  = state;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    load_tag1   = 1'b0;
    load_tag2   = 1'b0;
    load_valid1 = 1'b0;
    load_valid2 = 1'b0;
    load_data1  = 1'b0;
    load_data2  = 1'b0;
    load_dirty1 = 1'b0;
    load_dirty2 = 1'b0;
    load_lru    = 1'b0;
    lru_in      = 1'b0;
    valid1_in   = 1'b0;
    valid2_in   = 1'b0;
    dirty1_in   = 1'b0;
    dirty2_in   = 1'b0;
    eviction    = 1'b0;
    data_src    = 1'b0;
    paddr_sel   = 1'b0;
    refill_set  = 1'b0;
    refill_clr  = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    wb_inc      = 1'b0;

    case (state)
      IDLE: begin
        // Array strobes are held off while reset is asserted.
        if (req && reset_n) begin
          if (hit) begin
            mem_resp   = 1'b1;
            load_lru   = 1'b1;
            lru_in     = ~hit_way;
            hit_inc    = ~refill;
            refill_clr = 1'b1;
            if (wr) begin
              data_src = 1'b1;
              if (hit_way == WAY2) begin
                load_data2  = 1'b1;
                load_dirty2 = 1'b1;
                dirty2_in   = 1'b1;
              end else begin
                load_data1  = 1'b1;
                load_dirty1 = 1'b1;
                dirty1_in   = 1'b1;
              end
            end
          end else begin
            miss_inc   = 1'b1;
            next_state = victim_dirty(lru_way, dirty1_out, dirty2_out) ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        eviction   = 1'b1;
        paddr_sel  = 1'b1;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wb_inc     = 1'b1;
          next_state = ALLOCATE;
        end
      end

      ALLOCATE: begin
        eviction  = 1'b1;
        pmem_read = 1'b1;
        if (pmem_resp && reset_n) begin
          refill_set = 1'b1;
          next_state = IDLE;
          if (lru_way == WAY2) begin
            load_data2  = 1'b1;
            load_tag2   = 1'b1;
            load_valid2 = 1'b1;
            load_dirty2 = 1'b1;
            valid2_in   = 1'b1;
          end else begin
            load_data1  = 1'b1;
            load_tag1   = 1'b1;
            load_valid1 = 1'b1;
            load_dirty1 = 1'b1;
            valid1_in   = 1'b1;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  sat_counter #(.width(CNT_W)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (stat_clr),
    .inc     (hit_inc),
    .count   (hit_count)
  );

  sat_counter #(.width(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (stat_clr),
    .inc     (miss_inc),
    .count   (miss_count)
  );

  sat_counter #(.width(CNT_W)) u_wb_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (stat_clr),
    .inc     (wb_inc),
    .count   (wb_count)
  );

endmodule
